instr_rom_responder: RTL and testbench

Instruction-memory responder that serves the fetch stage.
- Each cycle it takes the next-PC address that the fetch stage drives.
- It returns the registered instruction word, which the fetch stage latches into decode.
- It honours the decode stall/clear controls so instruction data stays aligned with the PC pipeline registers.
- It owns a word-streaming program-load port. While loading, it holds the core off via core_hold.

---
 rtl/instr_rom_responder.sv | 121 ++++++++++++
 tb/tb_instr_rom_responder.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_rom_responder.sv
`default_nettype none
// ============================================================================
//  Module      : instr_rom_responder
//  Description : Instruction memory serving the fetch stage. It returns a
//                registered instruction word one cycle after the address and
//                honours the decode stall and clear controls. A
//                word-streaming load port fills the array while the core is
//                held off through core_hold.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_rom_responder #(
  parameter int          DEPTH         = 1024,
  parameter logic [31:0] BASE_ADDR     = 32'h0000_0000,
  parameter bit          LOAD_ON_RESET = 1'b1,
  parameter logic [31:0] NOP_INSTR     = 32'h0000_0013
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [31:0]            addr,
  input  logic                   de_stall,
  input  logic                   de_clear,
  output logic [31:0]            instr,
  output logic                   addr_fault,
  input  logic                   ld_valid,
  input  logic [31:0]            ld_data,
  input  logic                   ld_last,
  output logic                   ld_ready,
  output logic                   core_hold,
  output logic                   load_err,
  output logic [$clog2(DEPTH):0] load_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  localparam logic [0:0] ST_LOAD     = 1'b0;
  localparam logic [0:0] ST_RUN      = 1'b1;
  localparam logic [0:0] RESET_STATE = LOAD_ON_RESET ? ST_LOAD : ST_RUN;

  logic [0:0]    state;
  logic [31:0]   mem [DEPTH];

  logic          in_load;
  logic          load_full;
  logic          load_fire;
  logic          load_overflow;

  logic [32:0]   diff;
  logic          below_base;
  logic [31:0]   offset;
  logic [AW-1:0] rd_index;
  logic          rd_fault;
  logic [31:0]   rd_word;

  // Load-port handshake. load_count never exceeds DEPTH, so "full" is
  // the same condition as load_count >= DEPTH.
  assign in_load       = (state == ST_LOAD);
  assign load_full     = (load_count == FULL_COUNT);
  assign ld_ready      = in_load && !load_full;
  assign core_hold     = in_load;
  assign load_fire     = ld_valid && ld_ready;
  assign load_overflow = in_load && ld_valid && load_full;

  // Address decode. The subtraction is done one bit wider so the borrow
  // flags an address below BASE_ADDR without any wrap-around.
  assign diff       = {1'b0, addr} - {1'b0, BASE_ADDR};
  assign below_base = diff[32];
  assign offset     = diff[31:0];
  assign rd_index   = offset[AW+1:2];
  assign rd_fault   = (addr[1:0] != 2'b00) || below_base ||
                      ((offset >> 2) >= 32'(DEPTH));
  assign rd_word    = mem[rd_index];

  // Load/run sequencing, load counter and sticky overflow flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= RESET_STATE;
      load_count <= '0;
      load_err   <= 1'b0;
    end else if (in_load) begin
      if (load_fire) begin
        load_count <= load_count + CW'(1);
        if (ld_last) begin
          state <= ST_RUN;
        end
      end else if (load_overflow) begin
        load_err <= 1'b1;
        state    <= ST_RUN;
      end
    end
  end

  // Array write port. The array is not reset, and no write happens while
  // reset is held.
  always_ff @(posedge clk) begin
    if (load_fire && !reset) begin
      mem[load_count[AW-1:0]] <= ld_data;
    end
  end

  // Registered instruction output. In LOAD the output is a NOP. In RUN,
  // clear has priority over stall, and stall has priority over a new read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr      <= '0;
      addr_fault <= 1'b0;
    end else if (in_load) begin
      instr      <= NOP_INSTR;
      addr_fault <= 1'b0;
    end else if (de_clear) begin
      instr      <= '0;
      addr_fault <= 1'b0;
    end else if (!de_stall) begin
      instr      <= rd_fault ? NOP_INSTR : rd_word;
      addr_fault <= rd_fault;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instr_rom_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_rom_responder
//  Description : Self-checking bench for instr_rom_responder. It uses a
//                vector table for the read-path cases, hand-written load,
//                overflow and async-reset sequences, and a randomized run
//                checked against a behavioural memory model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_rom_responder;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int          A_DEPTH = 1024;
  localparam logic [31:0] W0 = 32'h1111_1111;
  localparam logic [31:0] W1 = 32'h2222_2222;
  localparam logic [31:0] W2 = 32'h3333_3333;
  localparam logic [31:0] W3 = 32'h4444_4444;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance: DEPTH=1024, BASE=0, load after reset
  logic        reset, de_stall, de_clear, ld_valid, ld_last;
  logic [31:0] addr, ld_data, instr;
  logic        addr_fault, ld_ready, core_hold, load_err;
  logic [10:0] load_count;

  // Small instance: DEPTH=4, BASE=0x100, used for overflow and base checks
  logic        b_reset, b_de_stall, b_de_clear, b_ld_valid, b_ld_last;
  logic [31:0] b_addr, b_ld_data, b_instr;
  logic        b_addr_fault, b_ld_ready, b_core_hold, b_load_err;
  logic [2:0]  b_load_count;

  // Run-after-reset instance: DEPTH=16, LOAD_ON_RESET=0
  logic        c_reset, c_zero;
  logic [31:0] c_addr, c_data, c_instr;
  logic        c_addr_fault, c_ld_ready, c_core_hold, c_load_err;
  logic [4:0]  c_load_count;

  instr_rom_responder #(
    .DEPTH(A_DEPTH), .BASE_ADDR(32'h0), .LOAD_ON_RESET(1'b1), .NOP_INSTR(NOP)
  ) dut (
    .clk(clk), .reset(reset), .addr(addr), .de_stall(de_stall), .de_clear(de_clear),
    .instr(instr), .addr_fault(addr_fault), .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_last(ld_last), .ld_ready(ld_ready), .core_hold(core_hold),
    .load_err(load_err), .load_count(load_count)
  );

  instr_rom_responder #(
    .DEPTH(4), .BASE_ADDR(32'h0000_0100), .LOAD_ON_RESET(1'b1), .NOP_INSTR(NOP)
  ) dut_b (
    .clk(clk), .reset(b_reset), .addr(b_addr), .de_stall(b_de_stall), .de_clear(b_de_clear),
    .instr(b_instr), .addr_fault(b_addr_fault), .ld_valid(b_ld_valid), .ld_data(b_ld_data),
    .ld_last(b_ld_last), .ld_ready(b_ld_ready), .core_hold(b_core_hold),
    .load_err(b_load_err), .load_count(b_load_count)
  );

  instr_rom_responder #(
    .DEPTH(16), .BASE_ADDR(32'h0), .LOAD_ON_RESET(1'b0), .NOP_INSTR(NOP)
  ) dut_c (
    .clk(clk), .reset(c_reset), .addr(c_addr), .de_stall(c_zero), .de_clear(c_zero),
    .instr(c_instr), .addr_fault(c_addr_fault), .ld_valid(c_zero), .ld_data(c_data),
    .ld_last(c_zero), .ld_ready(c_ld_ready), .core_hold(c_core_hold),
    .load_err(c_load_err), .load_count(c_load_count)
  );

  int vectors;
  int miscompares;

  typedef struct {
    logic [31:0] addr;
    logic        stall;
    logic        clear;
    logic [31:0] exp_instr;
    logic        exp_fault;
  } vec_t;

  vec_t        tbl[$];
  logic [31:0] words [4];
  logic [31:0] model_mem [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic [31:0] a, input logic s, input logic c,
                              input logic [31:0] ei, input logic ef);
    vec_t v;
    v.addr = a; v.stall = s; v.clear = c; v.exp_instr = ei; v.exp_fault = ef;
    return v;
  endfunction

  task automatic b_read(input logic [31:0] a, input logic [31:0] ei, input logic ef);
    b_addr = a;
    tick;
    chk($sformatf("b_read_%h_instr", a), b_instr, ei);
    chk($sformatf("b_read_%h_fault", a), 32'(b_addr_fault), 32'(ef));
  endtask

  // Watchdog: the bench must never hang
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [31:0] exp_i;
    logic        exp_f;
    logic        f;
    logic        v;
    int          k;
    int          cyc;

    vectors = 0; miscompares = 0;
    words[0] = W0; words[1] = W1; words[2] = W2; words[3] = W3;

    reset = 1'b1; addr = '0; de_stall = 1'b0; de_clear = 1'b0;
    ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0;
    b_reset = 1'b1; b_addr = '0; b_de_stall = 1'b0; b_de_clear = 1'b0;
    b_ld_valid = 1'b0; b_ld_data = '0; b_ld_last = 1'b0;
    c_reset = 1'b1; c_zero = 1'b0; c_data = '0; c_addr = 32'd64;

    // Reset values are checked before any clock edge
    #2;
    chk("rst_instr",      instr,              32'h0);
    chk("rst_fault",      32'(addr_fault),    32'd0);
    chk("rst_ld_ready",   32'(ld_ready),      32'd1);
    chk("rst_core_hold",  32'(core_hold),     32'd1);
    chk("rst_load_err",   32'(load_err),      32'd0);
    chk("rst_load_count", 32'(load_count),    32'd0);
    chk("c_rst_ld_ready", 32'(c_ld_ready),    32'd0);
    chk("c_rst_hold",     32'(c_core_hold),   32'd0);
    chk("c_rst_instr",    c_instr,            32'h0);
    chk("c_rst_err",      32'(c_load_err),    32'd0);
    chk("c_rst_count",    32'(c_load_count),  32'd0);

    tick;
    reset = 1'b0; c_reset = 1'b0;
    tick;
    chk("load_idle_instr", instr,            NOP);
    chk("load_idle_count", 32'(load_count),  32'd0);
    chk("load_idle_hold",  32'(core_hold),   32'd1);
    chk("c_run_instr",     c_instr,          NOP);
    chk("c_run_fault",     32'(c_addr_fault), 32'd1);

    // Test 1: stream four words, ld_last on the fourth
    for (int i = 0; i < 4; i++) begin
      ld_valid = 1'b1; ld_data = words[i]; ld_last = (i == 3);
      chk($sformatf("ld%0d_ready", i), 32'(ld_ready),  32'd1);
      chk($sformatf("ld%0d_hold", i),  32'(core_hold), 32'd1);
      tick;
      chk($sformatf("ld%0d_instr", i), instr,            NOP);
      chk($sformatf("ld%0d_fault", i), 32'(addr_fault),  32'd0);
    end
    ld_valid = 1'b0; ld_last = 1'b0;
    chk("ld_done_hold",  32'(core_hold),  32'd0);
    chk("ld_done_count", 32'(load_count), 32'd4);
    chk("ld_done_ready", 32'(ld_ready),   32'd0);
    chk("ld_done_err",   32'(load_err),   32'd0);

    // Read, stall, clear and fault vectors
    tbl.push_back(mk(32'd0,  1'b0, 1'b0, W0,    1'b0));
    tbl.push_back(mk(32'd4,  1'b0, 1'b0, W1,    1'b0));
    tbl.push_back(mk(32'd8,  1'b0, 1'b0, W2,    1'b0));
    tbl.push_back(mk(32'd12, 1'b0, 1'b0, W3,    1'b0));
    tbl.push_back(mk(32'd0,  1'b0, 1'b0, W0,    1'b0));
    tbl.push_back(mk(32'd0,  1'b1, 1'b0, W0,    1'b0));
    tbl.push_back(mk(32'd4,  1'b1, 1'b0, W0,    1'b0));
    tbl.push_back(mk(32'd8,  1'b1, 1'b0, W0,    1'b0));
    tbl.push_back(mk(32'd8,  1'b0, 1'b0, W2,    1'b0));
    tbl.push_back(mk(32'd12, 1'b1, 1'b1, 32'h0, 1'b0));
    tbl.push_back(mk(32'd12, 1'b0, 1'b0, W3,    1'b0));
    tbl.push_back(mk(32'd2,  1'b0, 1'b0, NOP,   1'b1));
    tbl.push_back(mk(32'd4096, 1'b0, 1'b0, NOP, 1'b1));
    tbl.push_back(mk(32'd4,  1'b0, 1'b0, W1,    1'b0));
    tbl.push_back(mk(32'd1,  1'b0, 1'b0, NOP,   1'b1));
    tbl.push_back(mk(32'd8,  1'b1, 1'b0, NOP,   1'b1));
    tbl.push_back(mk(32'd8,  1'b0, 1'b0, W2,    1'b0));
    tbl.push_back(mk(32'hFFFF_FFFC, 1'b0, 1'b0, NOP,   1'b1));
    tbl.push_back(mk(32'hFFFF_FFFC, 1'b0, 1'b1, 32'h0, 1'b0));
    tbl.push_back(mk(32'd0,  1'b0, 1'b0, W0,    1'b0));
    for (int i = 0; i < tbl.size(); i++) begin
      addr = tbl[i].addr; de_stall = tbl[i].stall; de_clear = tbl[i].clear;
      tick;
      chk($sformatf("vec%0d_instr", i), instr,            tbl[i].exp_instr);
      chk($sformatf("vec%0d_fault", i), 32'(addr_fault),  32'(tbl[i].exp_fault));
    end
    de_stall = 1'b0; de_clear = 1'b0;

    // The load port is ignored in RUN
    ld_valid = 1'b1; ld_data = 32'hDEAD_BEEF; addr = 32'd0;
    chk("run_ready", 32'(ld_ready), 32'd0);
    tick;
    chk("run_count", 32'(load_count), 32'd4);
    chk("run_hold",  32'(core_hold),  32'd0);
    chk("run_word0", instr,           W0);
    ld_valid = 1'b0;

    // Test 6: asynchronous reset in the middle of a load
    reset = 1'b1;
    tick;
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      ld_valid = 1'b1; ld_data = $urandom; ld_last = 1'b0;
      tick;
    end
    chk("mid_count", 32'(load_count), 32'd2);
    #3;
    reset = 1'b1;
    #1;
    chk("async_instr", instr,            32'h0);
    chk("async_count", 32'(load_count),  32'd0);
    chk("async_hold",  32'(core_hold),   32'd1);
    chk("async_ready", 32'(ld_ready),    32'd1);
    chk("async_fault", 32'(addr_fault),  32'd0);
    tick;
    reset = 1'b0;

    // Reload 16 random words with random bubbles
    k = 0; cyc = 0;
    while (k < 16 && cyc < 200) begin
      v = ($urandom_range(0, 2) != 0);
      ld_valid = v; ld_data = $urandom; ld_last = v && (k == 15);
      chk("reload_ready", 32'(ld_ready), 32'd1);
      tick;
      chk("reload_instr", instr, NOP);
      if (v) begin
        model_mem[k] = ld_data;
        k++;
      end
      cyc++;
    end
    chk("reload_done", 32'(k), 32'd16);
    ld_valid = 1'b0; ld_last = 1'b0;
    chk("reload_hold",  32'(core_hold),  32'd0);
    chk("reload_count", 32'(load_count), 32'd16);

    // Randomized reads against the memory model
    exp_i = NOP; exp_f = 1'b0;
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: a = 32'($urandom_range(0, 15)) << 2;
        6:       a = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(1, 3));
        7:       a = 32'd4096 + (32'($urandom_range(0, 1000)) << 2);
        8:       a = 32'hFFFF_FFFC;
        default: a = 32'h8000_0000 | $urandom;
      endcase
      addr = a;
      de_stall = ($urandom_range(0, 3) == 0);
      de_clear = ($urandom_range(0, 5) == 0);
      ld_valid = $urandom_range(0, 1) == 1;
      if (de_clear) begin
        exp_i = 32'h0; exp_f = 1'b0;
      end else if (!de_stall) begin
        f = (a % 4 != 0) || (a / 4 >= A_DEPTH);
        if (f) exp_i = NOP;
        else   exp_i = model_mem[a[5:2]];
        exp_f = f;
      end
      tick;
      chk($sformatf("rnd%0d_a%h_instr", n, a), instr,           exp_i);
      chk($sformatf("rnd%0d_a%h_fault", n, a), 32'(addr_fault), 32'(exp_f));
    end
    ld_valid = 1'b0; de_stall = 1'b0; de_clear = 1'b0;
    chk("rnd_count", 32'(load_count), 32'd16);

    // Test 5: overflow on the DEPTH=4 instance, no ld_last
    b_reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      b_ld_valid = 1'b1; b_ld_data = 32'hB0B0_0000 + 32'(i); b_ld_last = 1'b0;
      chk($sformatf("b_ld%0d_ready", i), 32'(b_ld_ready), (i < 4) ? 32'd1 : 32'd0);
      if (i == 4) begin
        chk("b_full_count", 32'(b_load_count), 32'd4);
        chk("b_full_err",   32'(b_load_err),   32'd0);
        chk("b_full_hold",  32'(b_core_hold),  32'd1);
      end
      tick;
    end
    chk("b_ovf_err",   32'(b_load_err),   32'd1);
    chk("b_ovf_count", 32'(b_load_count), 32'd4);
    chk("b_ovf_hold",  32'(b_core_hold),  32'd0);
    chk("b_ovf_ready", 32'(b_ld_ready),   32'd0);
    chk("b_ovf_instr", b_instr,           NOP);
    b_addr = 32'h0;
    tick;
    chk("b_below_instr", b_instr,            NOP);
    chk("b_below_fault", 32'(b_addr_fault),  32'd1);
    chk("b_run_count",   32'(b_load_count),  32'd4);
    b_ld_valid = 1'b0;
    b_read(32'h0000_0100, 32'hB0B0_0000, 1'b0);
    b_read(32'h0000_010C, 32'hB0B0_0003, 1'b0);
    b_read(32'h0000_0110, NOP,           1'b1);
    b_read(32'h0000_0102, NOP,           1'b1);
    b_read(32'h0000_00FC, NOP,           1'b1);
    b_read(32'h0000_0104, 32'hB0B0_0001, 1'b0);
    chk("b_err_sticky", 32'(b_load_err), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
